// File: rtl/swerv_trace_fifo.sv
// swerv_trace_fifo: captures up to two retired-instruction trace records per cycle into a
// DEPTH-entry FIFO, with a drop counter and a sticky overflow flag.
// Ports: clk/rst (sync active-high); trace_en plus trace_rv_i_* carry slot0 [31:0] / slot1 [63:32] retire info;
// out_valid/out_ready handshake the head entry (out_pc, out_insn, out_exc, out_intr, out_ecause);
// level = entry count; overflow/drop_cnt record dropped entries, cleared by clr_ovf.
module swerv_trace_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       trace_en,
    input  logic [2:0]                 trace_rv_i_valid_ip,
    input  logic [63:0]                trace_rv_i_insn_ip,
    input  logic [63:0]                trace_rv_i_address_ip,
    input  logic [2:0]                 trace_rv_i_exception_ip,
    input  logic [2:0]                 trace_rv_i_interrupt_ip,
    input  logic [4:0]                 trace_rv_i_ecause_ip,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_insn,
    output logic                       out_exc,
    output logic                       out_intr,
    output logic [4:0]                 out_ecause,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic [15:0]                drop_cnt,
    input  logic                       clr_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0] L_DM1 = (AW+1)'(DEPTH - 1);

    logic [70:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_level;
    logic          r_ovf;
    logic [15:0]   r_drop;

    logic          w_v0, w_v1, w_s0_wr, w_s1_wr, w_pop;
    logic [1:0]    w_ncand, w_npush, w_drops;
    logic [AW-1:0] w_s1_idx;
    logic [70:0]   w_e0, w_e1, w_head;
    logic [16:0]   w_dsum;
    logic [15:0]   w_dbase;
    logic          w_unused;

    assign w_unused = ^{trace_rv_i_valid_ip[2], trace_rv_i_exception_ip[2], trace_rv_i_interrupt_ip[2]};

    assign w_v0 = trace_en & trace_rv_i_valid_ip[0];
    assign w_v1 = trace_en & trace_rv_i_valid_ip[1];
    // Space is judged on the start-of-cycle level only; a same-cycle pop frees nothing yet.
    assign w_s0_wr = w_v0 & (r_level < L_DEPTH);
    assign w_s1_wr = w_v1 & (w_v0 ? (r_level < L_DM1) : (r_level < L_DEPTH));
    assign w_s1_idx = r_wptr + AW'(w_v0);
    assign w_ncand = {1'b0, w_v0} + {1'b0, w_v1};
    assign w_npush = {1'b0, w_s0_wr} + {1'b0, w_s1_wr};
    assign w_drops = w_ncand - w_npush;
    assign w_pop = out_valid & out_ready;

    assign w_e0 = {trace_rv_i_address_ip[31:0], trace_rv_i_insn_ip[31:0],
                   trace_rv_i_exception_ip[0], trace_rv_i_interrupt_ip[0],
                   (trace_rv_i_exception_ip[0] | trace_rv_i_interrupt_ip[0]) ? trace_rv_i_ecause_ip : 5'd0};
    assign w_e1 = {trace_rv_i_address_ip[63:32], trace_rv_i_insn_ip[63:32],
                   trace_rv_i_exception_ip[1], trace_rv_i_interrupt_ip[1],
                   (trace_rv_i_exception_ip[1] | trace_rv_i_interrupt_ip[1]) ? trace_rv_i_ecause_ip : 5'd0};

    // Same-cycle clear plus drops leaves only this cycle's drops counted.
    assign w_dbase = clr_ovf ? 16'd0 : r_drop;
    assign w_dsum = {1'b0, w_dbase} + 17'(w_drops);

    assign w_head = r_mem[r_rptr];
    assign {out_pc, out_insn, out_exc, out_intr, out_ecause} = w_head;
    assign out_valid = r_level != '0;
    assign level = r_level;
    assign overflow = r_ovf;
    assign drop_cnt = r_drop;

    always_ff @(posedge clk) begin
        if (w_s0_wr) r_mem[r_wptr] <= w_e0;
        if (w_s1_wr) r_mem[w_s1_idx] <= w_e1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
            r_drop  <= '0;
        end else begin
            r_wptr  <= r_wptr + AW'(w_npush);
            r_rptr  <= r_rptr + AW'(w_pop);
            r_level <= r_level + (AW+1)'(w_npush) - (AW+1)'(w_pop);
            r_ovf   <= (r_ovf & ~clr_ovf) | (w_drops != 2'd0);
            r_drop  <= w_dsum[16] ? 16'hFFFF : w_dsum[15:0];
        end
    end
endmodule

// File: tb/tb_swerv_trace_fifo.sv
// tb_swerv_trace_fifo: randomized directed-sequence bench against a queue-based reference model.
module tb_swerv_trace_fifo;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst, trace_en, out_ready, clr_ovf;
    logic [2:0]  valid, exc, intr;
    logic [63:0] insn, addr;
    logic [4:0]  ecause;
    logic        out_valid, out_exc, out_intr, overflow;
    logic [31:0] out_pc, out_insn;
    logic [4:0]  out_ecause;
    logic [4:0]  level;
    logic [15:0] drop_cnt;

    always #5 clk = ~clk;

    swerv_trace_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .trace_en(trace_en),
        .trace_rv_i_valid_ip(valid), .trace_rv_i_insn_ip(insn),
        .trace_rv_i_address_ip(addr), .trace_rv_i_exception_ip(exc),
        .trace_rv_i_interrupt_ip(intr), .trace_rv_i_ecause_ip(ecause),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_insn(out_insn), .out_exc(out_exc),
        .out_intr(out_intr), .out_ecause(out_ecause),
        .level(level), .overflow(overflow), .drop_cnt(drop_cnt), .clr_ovf(clr_ovf)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
        logic        exc;
        logic        intr;
        logic [4:0]  ec;
    } ent_t;

    ent_t        q[$];
    int unsigned m_drop;
    logic        m_ovf;
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic en, input logic [2:0] v, input logic [2:0] ex,
                        input logic [2:0] it, input logic [31:0] pc0, input logic [31:0] pc1,
                        input logic [31:0] in0, input logic [31:0] in1, input logic [4:0] ec,
                        input logic rdy, input logic clr);
        ent_t        c[$];
        ent_t        e;
        int          free;
        int          drops;
        int unsigned base;
        rst = r; trace_en = en; valid = v; exc = ex; intr = it;
        addr = {pc1, pc0}; insn = {in1, in0}; ecause = ec; out_ready = rdy; clr_ovf = clr;
        if (r) begin
            q.delete();
            m_drop = 0;
            m_ovf = 1'b0;
        end else begin
            free = DEPTH - q.size();
            drops = 0;
            if (en && v[0]) begin
                e.pc = pc0; e.insn = in0; e.exc = ex[0]; e.intr = it[0];
                e.ec = (ex[0] || it[0]) ? ec : 5'd0;
                c.push_back(e);
            end
            if (en && v[1]) begin
                e.pc = pc1; e.insn = in1; e.exc = ex[1]; e.intr = it[1];
                e.ec = (ex[1] || it[1]) ? ec : 5'd0;
                c.push_back(e);
            end
            if (q.size() != 0 && rdy) void'(q.pop_front());
            foreach (c[i]) begin
                if (free > 0) begin
                    q.push_back(c[i]);
                    free--;
                end else drops++;
            end
            base = clr ? 0 : m_drop;
            m_drop = (base + drops > 65535) ? 65535 : base + drops;
            m_ovf = (clr ? 1'b0 : m_ovf) | (drops != 0);
        end
        @(posedge clk);
        #1;
        chk("level", 32'(level), 32'(q.size()));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("drop_cnt", 32'(drop_cnt), m_drop);
        if (q.size() != 0) begin
            chk("out_pc", out_pc, q[0].pc);
            chk("out_insn", out_insn, q[0].insn);
            chk("out_exc", 32'(out_exc), 32'(q[0].exc));
            chk("out_intr", 32'(out_intr), 32'(q[0].intr));
            chk("out_ecause", 32'(out_ecause), 32'(q[0].ec));
        end
    endtask

    // Random payload; bit 2 of valid/exc/intr is randomized too and must have no effect.
    task automatic rstep(input logic en, input logic [1:0] v, input logic rdy, input logic clr);
        step(1'b0, en, {1'($urandom), v}, 3'($urandom), 3'($urandom),
             $urandom, $urandom, $urandom, $urandom, 5'($urandom), rdy, clr);
    endtask

    initial begin
        step(1'b1, 1'b0, 3'b0, 3'b0, 3'b0, 0, 0, 0, 0, 5'd0, 1'b0, 1'b0);
        chk("reset_level", 32'(level), 32'd0);
        chk("reset_valid", 32'(out_valid), 32'd0);

        step(1'b0, 1'b1, 3'b011, 3'b0, 3'b0, 32'h100, 32'h104, 32'h13, 32'h93, 5'd0, 1'b0, 1'b0);
        chk("basic_pc", out_pc, 32'h100);
        chk("basic_level", 32'(level), 32'd2);
        rstep(1'b0, 2'b11, 1'b0, 1'b0);
        rstep(1'b0, 2'b00, 1'b1, 1'b0);
        chk("basic_pc2", out_pc, 32'h104);
        rstep(1'b0, 2'b00, 1'b1, 1'b0);
        chk("basic_empty", 32'(out_valid), 32'd0);

        step(1'b0, 1'b1, 3'b011, 3'b010, 3'b000, 32'h200, 32'h204, 32'h1, 32'h2, 5'd2, 1'b0, 1'b0);
        chk("ec_slot0", 32'(out_ecause), 32'd0);
        step(1'b0, 1'b0, 3'b0, 3'b0, 3'b0, 0, 0, 0, 0, 5'd0, 1'b1, 1'b0);
        chk("ec_slot1", 32'(out_ecause), 32'd2);
        chk("exc_slot1", 32'(out_exc), 32'd1);
        rstep(1'b0, 2'b00, 1'b1, 1'b0);

        for (int i = 0; i < 15; i++) rstep(1'b1, 2'b01, 1'b0, 1'b0);
        rstep(1'b1, 2'b11, 1'b0, 1'b0);
        chk("full_level", 32'(level), 32'd16);
        chk("full_drop", 32'(drop_cnt), 32'd1);
        rstep(1'b1, 2'b11, 1'b1, 1'b0);
        chk("fullpop_level", 32'(level), 32'd15);
        chk("fullpop_drop", 32'(drop_cnt), 32'd3);
        rstep(1'b1, 2'b01, 1'b0, 1'b0);
        rstep(1'b1, 2'b11, 1'b0, 1'b1);
        chk("clr_drop_same", 32'(drop_cnt), 32'd2);
        rstep(1'b0, 2'b00, 1'b0, 1'b1);
        chk("clr_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 20; i++) rstep(1'b1, 2'($urandom), 1'b1, 1'b0);

        for (int i = 0; i < 40; i++) rstep(1'b1, 2'b11, 1'b1, 1'b0);

        for (int i = 0; i < 400; i++)
            rstep(1'($urandom_range(0, 7) != 0), 2'($urandom), 1'($urandom), ($urandom_range(0, 31) == 0));

        for (int i = 0; i < 32780; i++) rstep(1'b1, 2'b11, 1'b0, 1'b0);
        chk("sat_drop", 32'(drop_cnt), 32'hFFFF);
        rstep(1'b1, 2'b11, 1'b0, 1'b1);
        chk("clr_sat_drop", 32'(drop_cnt), 32'd2);
        rstep(1'b0, 2'b00, 1'b1, 1'b1);
        chk("clr_sat_zero", 32'(drop_cnt), 32'd0);
        step(1'b1, 1'b1, 3'b011, 3'b0, 3'b0, 1, 2, 3, 4, 5'd0, 1'b1, 1'b1);
        chk("midrst_level", 32'(level), 32'd0);
        step(1'b0, 1'b1, 3'b001, 3'b0, 3'b0, 32'h300, 0, 32'h7, 0, 5'd0, 1'b0, 1'b0);
        chk("postrst_pc", out_pc, 32'h300);
        for (int i = 0; i < 100; i++) rstep(1'b1, 2'($urandom), 1'($urandom), 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
